updi_interface: RTL and testbench

Byte-level UPDI transaction engine sitting between a host-side command sequencer and the UART byte FIFOs of the single-wire UPDI PHY.
- TX path: frames an instruction (SYNC 0x55, opcode, payload bytes) into the UART TX FIFO, checking ACK bytes (0x40) at marked payload positions.
- RX path: moves a requested number of received bytes from the UART RX FIFO into a host-side output FIFO.
- Connected FIFOs have registered reads: `out` is valid the cycle after an accepted rd_en. Writes are captured on the clock edge when wr_en && !full.
- No echo stripping; the PHY removes echoes.

---
 rtl/updi_interface.sv | 263 ++++++++++++++++++++++++++
 tb/tb_updi_interface.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/updi_interface.sv
// UPDI byte-level transaction engine: frames SYNC/opcode/payload into the UART TX FIFO,
// checks ACKs, and moves received bytes from the UART RX FIFO to the host RX FIFO.
`timescale 1ns/1ps

package updi_pkg;
  typedef enum logic [2:0] {
    LDS = 3'd0, LD = 3'd1, STS = 3'd2, ST = 3'd3,
    LDCS = 3'd4, REPEAT = 3'd5, STCS = 3'd6, KEY = 3'd7
  } updi_instruction;
endpackage

module updi_interface
  import updi_pkg::*;
#(
  parameter int unsigned MAX_DATA_SIZE  = 64,
  parameter int unsigned DATA_ADDR_BITS = $clog2(MAX_DATA_SIZE),
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                              clk,
  input  logic                              rst,
  input  updi_instruction                   instruction,
  input  logic [1:0]                        size_a,
  input  logic [1:0]                        size_b,
  input  logic [1:0]                        ptr,
  input  logic [3:0]                        cs_addr,
  input  logic                              sib,
  input  logic [1:0]                        size_c,
  input  logic [MAX_DATA_SIZE-1:0][7:0]     data,
  input  logic [DATA_ADDR_BITS:0]           data_len,
  input  logic [MAX_DATA_SIZE-1:0]          wait_ack_after,
  input  logic                              tx_start,
  output logic                              tx_ready,
  output logic                              tx_done,
  input  logic [DATA_ADDR_BITS-1:0]         rx_n_bytes,
  input  logic                              rx_start,
  output logic                              rx_ready,
  output logic                              rx_done,
  output logic                              rx_timeout,
  output logic                              ack_error,
  output logic [7:0]                        out_rx_fifo_data,
  output logic                              out_rx_fifo_wr_en,
  input  logic                              out_rx_fifo_full,
  input  logic [7:0]                        uart_rx_fifo_data,
  output logic                              uart_rx_fifo_rd_en,
  input  logic                              uart_rx_fifo_empty,
  output logic [7:0]                        uart_tx_fifo_data,
  output logic                              uart_tx_fifo_wr_en,
  input  logic                              uart_tx_fifo_full
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]          TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0]          TMO_ONE  = 1;
  localparam logic [DATA_ADDR_BITS:0]   IDX_ONE  = 1;
  localparam logic [DATA_ADDR_BITS-1:0] CNT_ONE  = 1;

  typedef enum logic [2:0] {
    IDLE, TX_SYNC, TX_OPCODE, TX_DATA, ACK_REQ, ACK_CHECK, RX_REQ, RX_WRITE
  } state_t;

  state_t                      state_q, state_d;
  logic [7:0]                  opcode_q, opcode_d;
  logic [DATA_ADDR_BITS:0]     len_q, len_d, idx_q, idx_d;
  logic [MAX_DATA_SIZE-1:0]    mask_q, mask_d;
  logic [DATA_ADDR_BITS-1:0]   rx_cnt_q, rx_cnt_d;
  logic [TMO_W-1:0]            tmo_q, tmo_d;
  logic                        tx_done_q, tx_done_d, rx_done_q, rx_done_d;
  logic                        ack_error_q, ack_error_d, rx_timeout_q, rx_timeout_d;
  logic [7:0]                  opcode_enc;
  logic                        last_byte;

  assign tx_ready   = (state_q == IDLE);
  assign rx_ready   = (state_q == IDLE);
  assign tx_done    = tx_done_q;
  assign rx_done    = rx_done_q;
  assign ack_error  = ack_error_q;
  assign rx_timeout = rx_timeout_q;
  assign last_byte  = ((idx_q + IDX_ONE) == len_q);

  always_comb begin
    opcode_enc = '0;
    case (instruction)
      LDS:     opcode_enc = {4'h0, size_a, size_b};
      LD:      opcode_enc = {4'h2, ptr, size_b};
      STS:     opcode_enc = {4'h4, size_a, size_b};
      ST:      opcode_enc = {4'h6, ptr, size_b};
      LDCS:    opcode_enc = {4'h8, cs_addr};
      REPEAT:  opcode_enc = {4'hA, 2'b00, size_b};
      STCS:    opcode_enc = {4'hC, cs_addr};
      KEY:     opcode_enc = {4'hE, 1'b0, sib, size_c};
      default: opcode_enc = '0;
    endcase
  end

  // FIFO strobes are gated by the live full/empty flags so a strobe is only
  // ever raised on a cycle where the FIFO will actually accept it.
  always_comb begin
    uart_tx_fifo_wr_en = 1'b0;
    uart_tx_fifo_data  = '0;
    uart_rx_fifo_rd_en = 1'b0;
    out_rx_fifo_wr_en  = 1'b0;
    out_rx_fifo_data   = '0;
    case (state_q)
      TX_SYNC: begin
        uart_tx_fifo_wr_en = !uart_tx_fifo_full;
        uart_tx_fifo_data  = 8'h55;
      end
      TX_OPCODE: begin
        uart_tx_fifo_wr_en = !uart_tx_fifo_full;
        uart_tx_fifo_data  = opcode_q;
      end
      TX_DATA: begin
        uart_tx_fifo_wr_en = !uart_tx_fifo_full;
        uart_tx_fifo_data  = data[idx_q[DATA_ADDR_BITS-1:0]];
      end
      ACK_REQ:  uart_rx_fifo_rd_en = !uart_rx_fifo_empty;
      RX_REQ:   uart_rx_fifo_rd_en = !uart_rx_fifo_empty && !out_rx_fifo_full;
      RX_WRITE: begin
        out_rx_fifo_wr_en = 1'b1;
        out_rx_fifo_data  = uart_rx_fifo_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    len_d        = len_q;
    idx_d        = idx_q;
    mask_d       = mask_q;
    rx_cnt_d     = rx_cnt_q;
    tmo_d        = tmo_q;
    tx_done_d    = 1'b0;
    rx_done_d    = 1'b0;
    ack_error_d  = ack_error_q;
    rx_timeout_d = rx_timeout_q;
    case (state_q)
      IDLE: begin
        if (tx_start) begin
          ack_error_d  = 1'b0;
          rx_timeout_d = 1'b0;
          opcode_d     = opcode_enc;
          len_d        = data_len;
          mask_d       = wait_ack_after;
          idx_d        = '0;
          state_d      = TX_SYNC;
        end else if (rx_start) begin
          ack_error_d  = 1'b0;
          rx_timeout_d = 1'b0;
          tmo_d        = '0;
          if (rx_n_bytes == '0) begin
            rx_done_d = 1'b1;
          end else begin
            rx_cnt_d = rx_n_bytes;
            state_d  = RX_REQ;
          end
        end
      end
      TX_SYNC:   if (!uart_tx_fifo_full) state_d = TX_OPCODE;
      TX_OPCODE: begin
        if (!uart_tx_fifo_full) begin
          if (len_q == '0) begin
            tx_done_d = 1'b1;
            state_d   = IDLE;
          end else begin
            idx_d   = '0;
            state_d = TX_DATA;
          end
        end
      end
      TX_DATA: begin
        if (!uart_tx_fifo_full) begin
          if (mask_q[idx_q[DATA_ADDR_BITS-1:0]]) begin
            tmo_d   = '0;
            state_d = ACK_REQ;
          end else if (last_byte) begin
            tx_done_d = 1'b1;
            state_d   = IDLE;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      ACK_REQ: begin
        if (!uart_rx_fifo_empty) begin
          tmo_d   = '0;
          state_d = ACK_CHECK;
        end else if (tmo_q == TMO_LAST) begin
          rx_timeout_d = 1'b1;
          state_d      = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      ACK_CHECK: begin
        if (uart_rx_fifo_data != 8'h40) begin
          ack_error_d = 1'b1;
          state_d     = IDLE;
        end else if (last_byte) begin
          tx_done_d = 1'b1;
          state_d   = IDLE;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = TX_DATA;
        end
      end
      RX_REQ: begin
        // A full host FIFO freezes the timeout counter rather than advancing it.
        if (!out_rx_fifo_full) begin
          if (!uart_rx_fifo_empty) begin
            tmo_d   = '0;
            state_d = RX_WRITE;
          end else if (tmo_q == TMO_LAST) begin
            rx_timeout_d = 1'b1;
            state_d      = IDLE;
          end else begin
            tmo_d = tmo_q + TMO_ONE;
          end
        end
      end
      RX_WRITE: begin
        rx_cnt_d = rx_cnt_q - CNT_ONE;
        if (rx_cnt_q == CNT_ONE) begin
          rx_done_d = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = RX_REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      opcode_q     <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      mask_q       <= '0;
      rx_cnt_q     <= '0;
      tmo_q        <= '0;
      tx_done_q    <= 1'b0;
      rx_done_q    <= 1'b0;
      ack_error_q  <= 1'b0;
      rx_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      mask_q       <= mask_d;
      rx_cnt_q     <= rx_cnt_d;
      tmo_q        <= tmo_d;
      tx_done_q    <= tx_done_d;
      rx_done_q    <= rx_done_d;
      ack_error_q  <= ack_error_d;
      rx_timeout_q <= rx_timeout_d;
    end
  end

endmodule

// File: tb/tb_updi_interface.sv
// Directed bench for updi_interface with behavioural models of the UART TX/RX and host RX FIFOs.
`timescale 1ns/1ps

module tb_updi_interface;
  import updi_pkg::*;

  localparam int unsigned MDS = 64;
  localparam int unsigned AB  = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  updi_instruction       instruction;
  logic [1:0]            size_a, size_b, ptr, size_c;
  logic [3:0]            cs_addr;
  logic                  sib;
  logic [MDS-1:0][7:0]   data;
  logic [AB:0]           data_len;
  logic [MDS-1:0]        wait_ack_after;
  logic                  tx_start, tx_ready, tx_done;
  logic [AB-1:0]         rx_n_bytes;
  logic                  rx_start, rx_ready, rx_done, rx_timeout, ack_error;
  logic [7:0]            out_rx_fifo_data, uart_rx_fifo_data, uart_tx_fifo_data;
  logic                  out_rx_fifo_wr_en, out_rx_fifo_full;
  logic                  uart_rx_fifo_rd_en, uart_rx_fifo_empty;
  logic                  uart_tx_fifo_wr_en, uart_tx_fifo_full;

  updi_interface #(.MAX_DATA_SIZE(MDS), .DATA_ADDR_BITS(AB), .TIMEOUT_CYCLES(4096)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .size_a(size_a), .size_b(size_b),
    .ptr(ptr), .cs_addr(cs_addr), .sib(sib), .size_c(size_c), .data(data),
    .data_len(data_len), .wait_ack_after(wait_ack_after), .tx_start(tx_start),
    .tx_ready(tx_ready), .tx_done(tx_done), .rx_n_bytes(rx_n_bytes), .rx_start(rx_start),
    .rx_ready(rx_ready), .rx_done(rx_done), .rx_timeout(rx_timeout), .ack_error(ack_error),
    .out_rx_fifo_data(out_rx_fifo_data), .out_rx_fifo_wr_en(out_rx_fifo_wr_en),
    .out_rx_fifo_full(out_rx_fifo_full), .uart_rx_fifo_data(uart_rx_fifo_data),
    .uart_rx_fifo_rd_en(uart_rx_fifo_rd_en), .uart_rx_fifo_empty(uart_rx_fifo_empty),
    .uart_tx_fifo_data(uart_tx_fifo_data), .uart_tx_fifo_wr_en(uart_tx_fifo_wr_en),
    .uart_tx_fifo_full(uart_tx_fifo_full)
  );

  // FIFO models: TX/host capture on wr_en && !full; UART RX has a registered read port.
  logic [7:0]  txq[$];
  logic [7:0]  hostq[$];
  logic [7:0]  rxm [32];
  int unsigned rx_wp = 0;
  int unsigned rx_rp = 0;
  logic [7:0]  rx_out = 8'h00;
  int unsigned tx_done_cnt = 0;
  int unsigned rx_done_cnt = 0;
  int unsigned ack_err_cycles = 0;

  assign uart_rx_fifo_empty = (rx_wp == rx_rp);
  assign uart_rx_fifo_data  = rx_out;

  always @(posedge clk) begin
    if (uart_tx_fifo_wr_en && !uart_tx_fifo_full) txq.push_back(uart_tx_fifo_data);
    if (out_rx_fifo_wr_en && !out_rx_fifo_full) hostq.push_back(out_rx_fifo_data);
    if (uart_rx_fifo_rd_en && (rx_wp != rx_rp)) begin
      rx_out <= rxm[rx_rp % 32];
      rx_rp  <= rx_rp + 1;
    end
    if (tx_done) tx_done_cnt++;
    if (rx_done) rx_done_cnt++;
    if (ack_error) ack_err_cycles++;
  end

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] tx_pack(input int unsigned base, input int unsigned n);
    logic [63:0] p = '0;
    for (int i = 0; i < int'(n); i++) p = {p[55:0], txq[base + i]};
    return p;
  endfunction

  function automatic logic [63:0] host_pack(input int unsigned base, input int unsigned n);
    logic [63:0] p = '0;
    for (int i = 0; i < int'(n); i++) p = {p[55:0], hostq[base + i]};
    return p;
  endfunction

  task automatic push_rx(input logic [7:0] b);
    rxm[rx_wp % 32] = b;
    rx_wp++;
  endtask

  task automatic start_tx(input updi_instruction ins, input logic [1:0] a, input logic [1:0] b,
                          input logic [1:0] p, input logic [3:0] cs, input logic s,
                          input logic [1:0] c, input int unsigned len, input logic [63:0] mask,
                          input logic also_rx);
    @(negedge clk);
    instruction    = ins;
    size_a         = a;
    size_b         = b;
    ptr            = p;
    cs_addr        = cs;
    sib            = s;
    size_c         = c;
    data_len       = (AB+1)'(len);
    wait_ack_after = mask;
    rx_n_bytes     = '0;
    tx_start       = 1'b1;
    rx_start       = also_rx;
    @(negedge clk);
    tx_start = 1'b0;
    rx_start = 1'b0;
  endtask

  task automatic start_rx(input int unsigned n);
    @(negedge clk);
    rx_n_bytes = AB'(n);
    rx_start   = 1'b1;
    @(negedge clk);
    rx_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while (!(tx_ready && rx_ready) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {62'd0, tx_ready, rx_ready}, 64'd3);
    @(negedge clk);
  endtask

  typedef struct {
    updi_instruction ins;
    logic [1:0] b, p, c;
    logic [3:0] cs;
    logic       s;
    logic [7:0] exp;
  } op_t;

  op_t ops [7];
  int unsigned tb_base, hb_base, txd_base, rxd_base, ack_base;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    instruction = LDS; size_a = '0; size_b = '0; ptr = '0; cs_addr = '0; sib = 1'b0;
    size_c = '0; data = '0; data_len = '0; wait_ack_after = '0; tx_start = 1'b0;
    rx_n_bytes = '0; rx_start = 1'b0; out_rx_fifo_full = 1'b0; uart_tx_fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", {62'd0, tx_ready, rx_ready}, 64'd3);
    check("reset_flags", {60'd0, ack_error, rx_timeout, tx_done, rx_done}, 64'd0);
    check("reset_strobes", {61'd0, uart_tx_fifo_wr_en, uart_rx_fifo_rd_en, out_rx_fifo_wr_en}, 64'd0);

    // STS with ACKs after payload bytes 1 and 3
    data[0] = 8'h12; data[1] = 8'h34; data[2] = 8'h56; data[3] = 8'h78;
    tb_base = txq.size(); txd_base = tx_done_cnt; ack_base = ack_err_cycles;
    start_tx(STS, 2'b01, 2'b01, 2'b00, 4'h0, 1'b0, 2'b00, 4, 64'hA, 1'b0);
    repeat (10) @(negedge clk);
    check("sts_wait_ack1_ready", {63'd0, tx_ready}, 64'd0);
    check("sts_bytes_before_ack1", txq.size() - tb_base, 64'd4);
    push_rx(8'h40);
    repeat (10) @(negedge clk);
    check("sts_wait_ack2_ready", {63'd0, tx_ready}, 64'd0);
    check("sts_bytes_before_ack2", txq.size() - tb_base, 64'd6);
    push_rx(8'h40);
    wait_idle("sts_idle", 50);
    check("sts_tx_bytes", tx_pack(tb_base, 6), 64'h5545_1234_5678);
    check("sts_tx_count", txq.size() - tb_base, 64'd6);
    check("sts_tx_done_pulses", tx_done_cnt - txd_base, 64'd1);
    check("sts_no_ack_error", ack_err_cycles - ack_base, 64'd0);

    // LDS with TX FIFO held full briefly, then a 2-byte RX
    tb_base = txq.size(); txd_base = tx_done_cnt;
    uart_tx_fifo_full = 1'b1;
    start_tx(LDS, 2'b01, 2'b01, 2'b00, 4'h0, 1'b0, 2'b00, 2, 64'h0, 1'b0);
    repeat (5) @(negedge clk);
    check("lds_stall_no_write", txq.size() - tb_base, 64'd0);
    check("lds_stall_busy", {63'd0, tx_ready}, 64'd0);
    uart_tx_fifo_full = 1'b0;
    wait_idle("lds_idle", 50);
    check("lds_tx_bytes", tx_pack(tb_base, 4), 64'h5505_1234);
    check("lds_tx_count", txq.size() - tb_base, 64'd4);
    check("lds_tx_done_pulses", tx_done_cnt - txd_base, 64'd1);

    hb_base = hostq.size(); rxd_base = rx_done_cnt;
    push_rx(8'h56); push_rx(8'h78);
    start_rx(2);
    wait_idle("rx2_idle", 50);
    check("rx2_host_bytes", host_pack(hb_base, 2), 64'h5678);
    check("rx2_host_count", hostq.size() - hb_base, 64'd2);
    check("rx2_done_pulses", rx_done_cnt - rxd_base, 64'd1);

    // Bad ACK aborts
    tb_base = txq.size(); txd_base = tx_done_cnt;
    start_tx(STS, 2'b01, 2'b01, 2'b00, 4'h0, 1'b0, 2'b00, 2, 64'h1, 1'b0);
    repeat (8) @(negedge clk);
    push_rx(8'h00);
    wait_idle("nack_idle", 50);
    check("nack_ack_error", {63'd0, ack_error}, 64'd1);
    check("nack_tx_bytes", tx_pack(tb_base, 3), 64'h55_4512);
    check("nack_tx_count", txq.size() - tb_base, 64'd3);
    check("nack_no_tx_done", tx_done_cnt - txd_base, 64'd0);

    // Missing ACK times out
    tb_base = txq.size(); txd_base = tx_done_cnt;
    start_tx(STS, 2'b01, 2'b01, 2'b00, 4'h0, 1'b0, 2'b00, 1, 64'h1, 1'b0);
    check("tmo_start_clears_ack_error", {63'd0, ack_error}, 64'd0);
    repeat (4000) @(negedge clk);
    check("tmo_not_early", {62'd0, tx_ready, rx_timeout}, 64'd0);
    wait_idle("tmo_idle", 200);
    check("tmo_flag", {62'd0, rx_timeout, ack_error}, 64'd2);
    check("tmo_no_tx_done", tx_done_cnt - txd_base, 64'd0);
    check("tmo_tx_bytes", tx_pack(tb_base, 3), 64'h55_4512);

    // Opcode sweep, data_len=0; LD entry also raises rx_start to test priority
    ops[0] = '{LDCS,   2'b00, 2'b00, 2'b00, 4'h3, 1'b0, 8'h83};
    ops[1] = '{STCS,   2'b00, 2'b00, 2'b00, 4'h0, 1'b0, 8'hC0};
    ops[2] = '{KEY,    2'b00, 2'b00, 2'b00, 4'h0, 1'b0, 8'hE0};
    ops[3] = '{REPEAT, 2'b00, 2'b00, 2'b00, 4'h0, 1'b0, 8'hA0};
    ops[4] = '{ST,     2'b00, 2'b01, 2'b00, 4'h0, 1'b0, 8'h64};
    ops[5] = '{KEY,    2'b00, 2'b00, 2'b10, 4'h0, 1'b1, 8'hE6};
    ops[6] = '{LD,     2'b11, 2'b10, 2'b00, 4'h0, 1'b0, 8'h2B};
    for (int i = 0; i < 7; i++) begin
      tb_base = txq.size(); txd_base = tx_done_cnt; rxd_base = rx_done_cnt;
      start_tx(ops[i].ins, 2'b00, ops[i].b, ops[i].p, ops[i].cs, ops[i].s, ops[i].c,
               0, 64'h0, (i == 6));
      check($sformatf("op%0d_flags_cleared", i), {63'd0, rx_timeout}, 64'd0);
      wait_idle($sformatf("op%0d_idle", i), 20);
      check($sformatf("op%0d_bytes", i), tx_pack(tb_base, 2), {48'd0, 8'h55, ops[i].exp});
      check($sformatf("op%0d_count", i), txq.size() - tb_base, 64'd2);
      check($sformatf("op%0d_done", i), {tx_done_cnt - txd_base, rx_done_cnt - rxd_base}, {32'd1, 32'd0});
    end

    // Host FIFO full longer than the timeout: stall, no timeout, resume
    hb_base = hostq.size(); rxd_base = rx_done_cnt;
    push_rx(8'hA1); push_rx(8'hA2); push_rx(8'hA3);
    out_rx_fifo_full = 1'b1;
    start_rx(3);
    repeat (4200) @(negedge clk);
    check("full_no_write", hostq.size() - hb_base, 64'd0);
    check("full_no_pop", rx_wp - rx_rp, 64'd3);
    check("full_busy_no_tmo", {62'd0, rx_ready, rx_timeout}, 64'd0);
    out_rx_fifo_full = 1'b0;
    wait_idle("full_idle", 50);
    check("full_host_bytes", host_pack(hb_base, 3), 64'hA1A2A3);
    check("full_done", {rx_done_cnt - rxd_base, 31'd0, rx_timeout}, {32'd1, 32'd0});

    // Zero-length RX completes at once
    hb_base = hostq.size(); rxd_base = rx_done_cnt;
    start_rx(0);
    @(negedge clk);
    check("rx0_done", rx_done_cnt - rxd_base, 64'd1);
    check("rx0_no_write", hostq.size() - hb_base, 64'd0);
    check("rx0_idle", {62'd0, tx_ready, rx_ready}, 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
